// File: rtl/memory_router.sv
// rtl/memory_router.sv - address-decoding single-outstanding transaction router
//
// Purpose: routes each arbiter request to exactly one of four memory-mapped
// slaves (0=rom, 1=print, 2=clint, 3=bram), returns only the owning slave's
// response, and closes unmapped or hung accesses with an error response.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   memory_valid/instr/addr/     request from the arbiter
//   memory_wdata/wstrb
//   memory_rdata/ready/error     response to the arbiter
//   slave_valid[3:0]             one-hot request pulse per slave
//   slave_instr/addr/wdata/wstrb shared request fields (addr is window-relative)
//   slave_rdata[127:0]           per-slave read data, slave i at [32*i +: 32]
//   slave_ready[3:0]             per-slave response pulse
module memory_router #(
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter logic [31:0] ROM_TOP    = 32'h0000_1000,
  parameter logic [31:0] PRINT_BASE = 32'h0100_0000,
  parameter logic [31:0] PRINT_TOP  = 32'h0100_0004,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
  parameter logic [31:0] BRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] BRAM_TOP   = 32'h8010_0000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         memory_valid,
  input  logic         memory_instr,
  input  logic [31:0]  memory_addr,
  input  logic [31:0]  memory_wdata,
  input  logic [3:0]   memory_wstrb,
  output logic [31:0]  memory_rdata,
  output logic         memory_ready,
  output logic         memory_error,
  output logic [3:0]   slave_valid,
  output logic         slave_instr,
  output logic [31:0]  slave_addr,
  output logic [31:0]  slave_wdata,
  output logic [3:0]   slave_wstrb,
  input  logic [127:0] slave_rdata,
  input  logic [3:0]   slave_ready
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Reaching CNT_LAST in BUSY means the counter hits TIMEOUT-1 on this edge,
  // so the error response lands exactly TIMEOUT cycles after the request.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t          state, state_next;
  logic [1:0]      sel;
  logic [CW-1:0]   count;

  // Window test as a single unsigned compare on the offset: base <= a < top
  // is equivalent to (a - base) < (top - base) when base < top.
  logic [31:0] rom_off, print_off, clint_off, bram_off;
  logic        rom_hit, print_hit, clint_hit, bram_hit;

  assign rom_off   = memory_addr - ROM_BASE;
  assign print_off = memory_addr - PRINT_BASE;
  assign clint_off = memory_addr - CLINT_BASE;
  assign bram_off  = memory_addr - BRAM_BASE;

  assign rom_hit   = rom_off   < (ROM_TOP   - ROM_BASE);
  assign print_hit = print_off < (PRINT_TOP - PRINT_BASE);
  assign clint_hit = clint_off < (CLINT_TOP - CLINT_BASE);
  assign bram_hit  = bram_off  < (BRAM_TOP  - BRAM_BASE);

  logic        mapped;
  logic [1:0]  hit_idx;
  logic [31:0] hit_off;

  always_comb begin
    mapped  = 1'b0;
    hit_idx = 2'd0;
    hit_off = memory_addr;
    if (memory_valid) begin
      if (bram_hit) begin
        mapped  = 1'b1;
        hit_idx = 2'd3;
        hit_off = bram_off;
      end else if (clint_hit) begin
        mapped  = 1'b1;
        hit_idx = 2'd2;
        hit_off = clint_off;
      end else if (print_hit) begin
        mapped  = 1'b1;
        hit_idx = 2'd1;
        hit_off = print_off;
      end else if (rom_hit) begin
        mapped  = 1'b1;
        hit_idx = 2'd0;
        hit_off = rom_off;
      end
    end
  end

  logic        sel_ready;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_rdata = 32'd0;
    case (sel)
      2'd0:    sel_rdata = slave_rdata[31:0];
      2'd1:    sel_rdata = slave_rdata[63:32];
      2'd2:    sel_rdata = slave_rdata[95:64];
      default: sel_rdata = slave_rdata[127:96];
    endcase
  end

  assign sel_ready = slave_ready[sel];

  // A request in BUSY is only taken when it overlaps the current response;
  // otherwise it is a protocol violation and silently dropped.
  logic accept;
  assign accept = memory_valid && !reset &&
                  ((state == S_IDLE) || ((state == S_BUSY) && sel_ready));

  assign slave_valid = (accept && mapped) ? (4'b0001 << hit_idx) : 4'b0000;
  assign slave_instr = memory_instr;
  assign slave_addr  = hit_off;
  assign slave_wdata = memory_wdata;
  assign slave_wstrb = memory_wstrb;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      sel   <= 2'd0;
      count <= '0;
    end else begin
      state <= state_next;
      if (accept && mapped) begin
        sel <= hit_idx;
      end
      if (accept) begin
        count <= '0;
      end else if ((state == S_BUSY) && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

  // Next-state logic; a timeout reuses ERR to emit its error response.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = mapped ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        if (sel_ready) begin
          if (accept) begin
            state_next = mapped ? S_BUSY : S_ERR;
          end else begin
            state_next = S_IDLE;
          end
        end else if (count == CNT_LAST) begin
          state_next = S_ERR;
        end
      end
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic, gated while reset is asserted.
  always_comb begin
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = 32'd0;
    if (!reset) begin
      case (state)
        S_BUSY: begin
          if (sel_ready) begin
            memory_ready = 1'b1;
            memory_rdata = sel_rdata;
          end
        end
        S_ERR: begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_router.sv
// tb/tb_memory_router.sv - directed self-checking bench for memory_router
module tb_memory_router;

  logic         clock;
  logic         reset;
  logic         memory_valid;
  logic         memory_instr;
  logic [31:0]  memory_addr;
  logic [31:0]  memory_wdata;
  logic [3:0]   memory_wstrb;
  logic [31:0]  memory_rdata;
  logic         memory_ready;
  logic         memory_error;
  logic [3:0]   slave_valid;
  logic         slave_instr;
  logic [31:0]  slave_addr;
  logic [31:0]  slave_wdata;
  logic [3:0]   slave_wstrb;
  logic [127:0] slave_rdata;
  logic [3:0]   slave_ready;
  logic [31:0]  rd0, rd1, rd2, rd3;

  int n_cmp = 0;
  int n_err = 0;

  assign slave_rdata = {rd3, rd2, rd1, rd0};

  memory_router #(.TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .memory_error (memory_error),
    .slave_valid  (slave_valid),
    .slave_instr  (slave_instr),
    .slave_addr   (slave_addr),
    .slave_wdata  (slave_wdata),
    .slave_wstrb  (slave_wstrb),
    .slave_rdata  (slave_rdata),
    .slave_ready  (slave_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample combinational outputs mid-cycle, away from the edge.
  task automatic settle();
    #4;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    memory_valid = 1'b1;
    memory_addr  = a;
    memory_wdata = wd;
    memory_wstrb = ws;
  endtask

  task automatic idle_in();
    memory_valid = 1'b0;
    memory_addr  = 32'h0;
    memory_wdata = 32'h0;
    memory_wstrb = 4'h0;
    slave_ready  = 4'h0;
  endtask

  initial begin
    reset        = 1'b1;
    memory_instr = 1'b0;
    rd0 = 32'h1111_2222;
    rd1 = 32'h0000_1234;
    rd2 = 32'h5555_6666;
    rd3 = 32'hDEAD_BEEF;
    idle_in();

    // Reset: outputs gated even with a live request and ready.
    tick();
    req(32'h8000_0010, 32'h0, 4'h0);
    slave_ready = 4'b1000;
    settle();
    check("rst_slave_valid", {28'h0, slave_valid}, 32'h0);
    check("rst_ready", {31'h0, memory_ready}, 32'h0);
    check("rst_rdata", memory_rdata, 32'h0);
    tick();
    reset = 1'b0;
    idle_in();
    settle();
    check("idle_ready", {31'h0, memory_ready}, 32'h0);

    // Bram read, response after 3 cycles.
    tick();
    req(32'h8000_0010, 32'h0, 4'h0);
    memory_instr = 1'b1;
    settle();
    check("bram_valid", {28'h0, slave_valid}, 32'h8);
    check("bram_addr", slave_addr, 32'h10);
    check("bram_instr", {31'h0, slave_instr}, 32'h1);
    tick();
    idle_in();
    memory_instr = 1'b0;
    for (int k = 1; k < 3; k++) begin
      settle();
      check("bram_wait_ready", {31'h0, memory_ready}, 32'h0);
      tick();
    end
    slave_ready = 4'b1000;
    settle();
    check("bram_ready", {31'h0, memory_ready}, 32'h1);
    check("bram_rdata", memory_rdata, 32'hDEAD_BEEF);
    check("bram_error", {31'h0, memory_error}, 32'h0);

    // Print write.
    tick();
    idle_in();
    req(32'h0100_0000, 32'h41, 4'b0001);
    settle();
    check("print_valid", {28'h0, slave_valid}, 32'h2);
    check("print_addr", slave_addr, 32'h0);
    check("print_wdata", slave_wdata, 32'h41);
    check("print_wstrb", {28'h0, slave_wstrb}, 32'h1);
    tick();
    idle_in();
    slave_ready = 4'b0010;
    settle();
    check("print_ready", {31'h0, memory_ready}, 32'h1);
    check("print_rdata", memory_rdata, 32'h0000_1234);
    check("print_error", {31'h0, memory_error}, 32'h0);

    // Unmapped access.
    tick();
    idle_in();
    req(32'h4000_0000, 32'h0, 4'h0);
    settle();
    check("unmap_valid", {28'h0, slave_valid}, 32'h0);
    check("unmap_ready0", {31'h0, memory_ready}, 32'h0);
    tick();
    idle_in();
    slave_ready = 4'b1111;
    settle();
    check("unmap_ready", {31'h0, memory_ready}, 32'h1);
    check("unmap_error", {31'h0, memory_error}, 32'h1);
    check("unmap_rdata", memory_rdata, 32'h0);
    tick();
    idle_in();
    settle();
    check("unmap_ready_once", {31'h0, memory_ready}, 32'h0);

    // Clint timeout: response at request+16, late ready at +20 ignored.
    tick();
    req(32'h0200_0008, 32'h0, 4'h0);
    settle();
    check("clint_valid", {28'h0, slave_valid}, 32'h4);
    check("clint_addr", slave_addr, 32'h8);
    for (int k = 1; k <= 20; k++) begin
      tick();
      idle_in();
      if (k == 5) req(32'h0000_0008, 32'h0, 4'h0);
      if (k == 20) slave_ready = 4'b0100;
      settle();
      if (k == 5) check("busy_drop_valid", {28'h0, slave_valid}, 32'h0);
      if (k == 16) begin
        check("tmo_ready", {31'h0, memory_ready}, 32'h1);
        check("tmo_error", {31'h0, memory_error}, 32'h1);
        check("tmo_rdata", memory_rdata, 32'h0);
      end else begin
        check("tmo_no_ready", {31'h0, memory_ready}, 32'h0);
      end
    end

    // Back-to-back: bram ready at t with a new rom request.
    tick();
    idle_in();
    rd3 = 32'hCAFE_F00D;
    req(32'h8000_0020, 32'h0, 4'h0);
    tick();
    idle_in();
    req(32'h0000_0004, 32'h0, 4'h0);
    slave_ready = 4'b1000;
    settle();
    check("b2b_bram_ready", {31'h0, memory_ready}, 32'h1);
    check("b2b_bram_rdata", memory_rdata, 32'hCAFE_F00D);
    check("b2b_rom_valid", {28'h0, slave_valid}, 32'h1);
    check("b2b_rom_addr", slave_addr, 32'h4);
    tick();
    idle_in();
    slave_ready = 4'b1001;
    settle();
    check("b2b_rom_ready", {31'h0, memory_ready}, 32'h1);
    check("b2b_rom_rdata", memory_rdata, 32'h1111_2222);
    tick();
    idle_in();
    slave_ready = 4'b1000;
    settle();
    check("b2b_stray_ready", {31'h0, memory_ready}, 32'h0);

    // Reset while bram outstanding; stale ready afterwards ignored.
    tick();
    idle_in();
    req(32'h8000_0040, 32'h0, 4'h0);
    tick();
    idle_in();
    reset = 1'b1;
    req(32'h8000_0040, 32'h0, 4'h0);
    slave_ready = 4'b1000;
    settle();
    check("rst2_valid", {28'h0, slave_valid}, 32'h0);
    check("rst2_ready", {31'h0, memory_ready}, 32'h0);
    check("rst2_error", {31'h0, memory_error}, 32'h0);
    check("rst2_rdata", memory_rdata, 32'h0);
    tick();
    reset = 1'b0;
    idle_in();
    slave_ready = 4'b1000;
    settle();
    check("stale_ready", {31'h0, memory_ready}, 32'h0);
    tick();
    idle_in();
    req(32'h0000_0100, 32'h0, 4'h0);
    settle();
    check("post_rst_valid", {28'h0, slave_valid}, 32'h1);
    check("post_rst_addr", slave_addr, 32'h100);
    tick();
    idle_in();
    slave_ready = 4'b0001;
    settle();
    check("post_rst_ready", {31'h0, memory_ready}, 32'h1);
    check("post_rst_rdata", memory_rdata, 32'h1111_2222);
    tick();
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
